// File: rtl/recursive_doubling_adder_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : recursive_doubling_adder_pipe                                 |
// | Purpose  : Pipelined Kogge-Stone (recursive-doubling) adder/subtractor   |
// |            with one prefix level per stage and a valid/ready stream.     |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            in_valid/in_ready, a, b, cin, sub, tag    - operation input   |
// |            out_valid/out_ready, sum, cout, ovf,                          |
// |            tag_out                                   - result output     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module recursive_doubling_adder_pipe #(
  parameter int N     = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(N);

  // Prefix vectors are N+1 wide: bit 0 is position -1 (the carry-in,
  // modelled as a generate with zero propagate), bit j is position j-1.
  logic [N:0]       r_g   [0:LEVELS];
  logic [N:0]       r_p   [0:LEVELS];
  logic [N-1:0]     r_ps  [0:LEVELS];
  logic [TAG_W-1:0] r_tag [0:LEVELS];
  logic [LEVELS:0]  r_v;

  logic         w_stall;
  logic [N-1:0] w_b_eff;
  logic         w_c0;
  logic [N:0]   w_gf;
  logic         w_pf_top;
  logic         w_cout;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;

  // Positions 0..N-1 of the prefix tree are complete after LEVELS levels
  // (span 2^LEVELS >= N). The carry out of the top bit needs span N+1, so
  // it gets one extra combine against the already-complete position N-2
  // group; the overlap is harmless because the prefix operator is
  // idempotent over overlapping ranges.
  assign w_gf     = r_g[LEVELS];
  assign w_pf_top = r_p[LEVELS][N];
  assign w_cout   = w_gf[N] | (w_pf_top & w_gf[N-1]);

  function automatic logic [N:0] lo_mask(input int d);
    lo_mask = ((N+1)'(1) << d) - (N+1)'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        r_g[k]   <= '0;
        r_p[k]   <= '0;
        r_ps[k]  <= '0;
        r_tag[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      tag_out   <= '0;
    end else if (!w_stall) begin
      r_v <= {r_v[LEVELS-1:0], in_valid};

      if (in_valid) begin
        r_g[0]   <= {a & w_b_eff, w_c0};
        r_p[0]   <= {a ^ w_b_eff, 1'b0};
        r_ps[0]  <= a ^ w_b_eff;
        r_tag[0] <= tag;
      end

      // Level k combines position j with j - 2^(k-1). Low positions with
      // no partner shift in zeros for G (unchanged) and ones via the mask
      // for P (unchanged).
      for (int k = 1; k <= LEVELS; k++) begin
        if (r_v[k-1]) begin
          r_g[k]   <= r_g[k-1] | (r_p[k-1] & (r_g[k-1] << (1 << (k-1))));
          r_p[k]   <= r_p[k-1] & ((r_p[k-1] << (1 << (k-1))) | lo_mask(1 << (k-1)));
          r_ps[k]  <= r_ps[k-1];
          r_tag[k] <= r_tag[k-1];
        end
      end

      // Data fields only update for real results so bubbles hold them.
      out_valid <= r_v[LEVELS];
      if (r_v[LEVELS]) begin
        sum     <= r_ps[LEVELS] ^ w_gf[N-1:0];
        cout    <= w_cout;
        ovf     <= w_gf[N-1] ^ w_cout;
        tag_out <= r_tag[LEVELS];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recursive_doubling_adder_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_recursive_doubling_adder_pipe                              |
// | Purpose  : Scoreboard bench for widths 8, 64 and 13 run side by side.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_recursive_doubling_adder_pipe;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input int w, input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL N=%0d %s actual=%h required=%h", w, nm, act, req);
    end
  endtask

  for (genvar W = 0; W < 3; W++) begin : g_w
    localparam int NW = (W == 0) ? 8 : ((W == 1) ? 64 : 13);
    localparam int LV = $clog2(NW);

    logic             rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [NW-1:0]    a, b, sum;
    logic [TAG_W-1:0] tag, tag_out;

    recursive_doubling_adder_pipe #(.N(NW), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
    );

    typedef struct packed {
      logic [NW-1:0]    sum;
      logic             cout;
      logic             ovf;
      logic [TAG_W-1:0] tag;
      int unsigned      t;
      int unsigned      s;
    } exp_t;

    exp_t        q[$];
    int unsigned stall_cnt = 0;
    int unsigned hold_until = 0;
    bit          fresh = 1'b1;
    bit          rnd_ready = 1'b0;
    bit          done = 1'b0;
    int unsigned tagc = 0;

    // Reference: plain integer arithmetic in NW+1 bits; signed overflow
    // from operand/result signs.
    function automatic exp_t model(input logic [NW-1:0] x, input logic [NW-1:0] y,
                                   input logic ci, input logic sb, input logic [TAG_W-1:0] tg);
      logic [NW:0]   full;
      logic [NW-1:0] yy;
      exp_t          e;
      yy = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + (NW+1)'(sb ? 1'b1 : ci);
      e.sum  = full[NW-1:0];
      e.cout = full[NW];
      e.ovf  = (x[NW-1] == yy[NW-1]) && (e.sum[NW-1] != x[NW-1]);
      e.tag  = tg;
      e.t    = 0;
      e.s    = 0;
      return e;
    endfunction

    always @(posedge clk) begin
      #1;
      if (cyc < hold_until) out_ready = 1'b0;
      else if (rnd_ready)   out_ready = 1'($urandom_range(0, 1));
      else                  out_ready = 1'b1;
    end

    // Monitor: compares each newly presented result against the queue head.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
        if (out_valid && fresh) begin
          if (q.size() == 0) begin
            chk(NW, "spurious_out_valid", 128'(out_valid), 128'(0));
          end else begin
            e = q.pop_front();
            chk(NW, "sum", 128'(sum), 128'(e.sum));
            chk(NW, "cout", 128'(cout), 128'(e.cout));
            chk(NW, "ovf", 128'(ovf), 128'(e.ovf));
            chk(NW, "tag_out", 128'(tag_out), 128'(e.tag));
            chk(NW, "latency", 128'(cyc - e.t - (stall_cnt - e.s)), 128'(LV + 1));
          end
        end
        chk(NW, "in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
        if (out_valid && !out_ready) stall_cnt++;
        fresh = !out_valid || out_ready;
      end else begin
        fresh = 1'b1;
      end
    end

    // Drives one operation (entered just after a rising edge) and pushes its
    // expected result once acceptance on the coming edge is certain.
    task automatic send(input logic [NW-1:0] x, input logic [NW-1:0] y, input logic ci, input logic sb);
      int   n = 0;
      exp_t e;
      a = x; b = y; cin = ci; sub = sb; tag = tagc[TAG_W-1:0];
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk(NW, "accept_timeout", 128'(in_ready), 128'(1));
        return;
      end
      e = model(x, y, ci, sb, tagc[TAG_W-1:0]);
      e.t = cyc + 1;
      e.s = stall_cnt;
      q.push_back(e);
      tagc++;
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic wait_empty();
      int n = 0;
      in_valid = 1'b0;
      while (q.size() != 0 && n < 300) begin
        @(posedge clk);
        n++;
      end
      #1;
      chk(NW, "drain_remaining", 128'(q.size()), 128'(0));
    endtask

    initial begin
      logic [NW-1:0] ones, maxp, minn, lo;
      ones = '1;
      maxp = ones >> 1;
      minn = ~maxp;
      lo   = ones >> (NW / 2);
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(NW, "rst_out_valid", 128'(out_valid), 128'(0));
      chk(NW, "rst_sum", 128'(sum), 128'(0));
      chk(NW, "rst_cout", 128'(cout), 128'(0));
      chk(NW, "rst_ovf", 128'(ovf), 128'(0));
      chk(NW, "rst_tag_out", 128'(tag_out), 128'(0));
      chk(NW, "rst_in_ready", 128'(in_ready), 128'(1));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corners, issued back-to-back.
      send(ones, NW'(1), 1'b0, 1'b0);
      send(maxp, NW'(1), 1'b0, 1'b0);
      send(lo, ~lo, 1'b1, 1'b0);
      send(minn, NW'(1), 1'b1, 1'b1);
      send('0, '0, 1'b0, 1'b1);
      send(NW'(64'h176F64DC49F6BD2E), NW'(64'hA91592C2EB1DA4B4), 1'b0, 1'b0);
      send(ones, ones, 1'b1, 1'b0);
      send('0, NW'(1), 1'b0, 1'b1);
      wait_empty();

      // Random traffic under random back-pressure and one long stall.
      rnd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (i == 8) hold_until = cyc + 10;
        if ($urandom_range(0, 3) == 0) idle(1);
        send(NW'({$urandom(), $urandom()}), NW'({$urandom(), $urandom()}),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_empty();
      rnd_ready = 1'b0;
      idle(2);

      // Asynchronous reset with three operations in flight.
      for (int i = 0; i < 3; i++)
        send(NW'({$urandom(), $urandom()}), NW'({$urandom(), $urandom()}), 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk(NW, "midrst_out_valid", 128'(out_valid), 128'(0));
      chk(NW, "midrst_sum", 128'(sum), 128'(0));
      chk(NW, "midrst_cout", 128'(cout), 128'(0));
      chk(NW, "midrst_ovf", 128'(ovf), 128'(0));
      chk(NW, "midrst_tag_out", 128'(tag_out), 128'(0));
      chk(NW, "midrst_in_ready", 128'(in_ready), 128'(1));
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(12);
      send(maxp, NW'(1), 1'b1, 1'b0);
      wait_empty();
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_w[0].done && g_w[1].done && g_w[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=%0d cycles required=completion", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
